// File: rtl/token_thin_arbiter.sv
// token_thin_arbiter
//   Shares one serial token output among N_REQ serial token inputs. Each
//   input stream is thinned at a runtime ratio: one of every `ratio` tokens
//   is kept. Kept tokens wait in per-requester saturating credit counters,
//   and a round-robin arbiter drains them one token per cycle through a
//   valid/ready port.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   a          a[i]=1: one token from requester i this cycle
//   ratio      keep 1 of every `ratio` tokens (0 behaves as 1)
//   out_ready  consumer accepts the presented token this cycle
//   out_valid  at least one credit is pending
//   out_id     requester index of the presented token (0 when idle)
//   drop       drop[i] pulses for one cycle when a kept token is lost
//              because credit[i] was saturated
//   pending    credit counters, requester i at [i*CNT_W +: CNT_W]
module token_thin_arbiter #(
   parameter int N_REQ   = 4,
   parameter int CNT_W   = 4,
   parameter int RATIO_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         a,
   input  logic [RATIO_W-1:0]       ratio,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [$clog2(N_REQ)-1:0] out_id,
   output logic [N_REQ-1:0]         drop,
   output logic [N_REQ*CNT_W-1:0]   pending
);

   localparam int ID_W = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] MAXC = '1;

   logic [RATIO_W-1:0] phase  [N_REQ];
   logic [CNT_W-1:0]   credit [N_REQ];
   logic [ID_W-1:0]    rr;

   logic [RATIO_W-1:0] eff_m1;
   logic [N_REQ-1:0]   keep;
   logic [N_REQ-1:0]   grant;
   logic               found;
   logic [ID_W-1:0]    sel;
   logic [ID_W-1:0]    idx;

   // ratio 0 behaves as 1, so the keep threshold is eff-1 clamped at 0.
   always_comb begin
      eff_m1 = (ratio == '0) ? '0 : ratio - RATIO_W'(1);
   end

   // Round-robin search starting at rr. Wrap is done explicitly so that
   // non-power-of-two N_REQ works.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (int'(rr) + k >= N_REQ)
            idx = ID_W'(int'(rr) + k - N_REQ);
         else
            idx = ID_W'(int'(rr) + k);
         if (!found && credit[idx] != '0) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // The >= compare lets a ratio decrease keep the next token immediately.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         keep[i]  = a[i] && (phase[i] >= eff_m1);
         grant[i] = found && out_ready && (sel == ID_W'(i));
         pending[i*CNT_W +: CNT_W] = credit[i];
      end
   end

   assign out_valid = found;
   assign out_id    = sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            phase[i]  <= '0;
            credit[i] <= '0;
         end
         drop <= '0;
         rr   <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (a[i])
               phase[i] <= keep[i] ? '0 : phase[i] + RATIO_W'(1);
            drop[i] <= 1'b0;
            // A keep and a grant on the same requester cancel out.
            if (keep[i] && !grant[i]) begin
               if (credit[i] == MAXC)
                  drop[i] <= 1'b1;
               else
                  credit[i] <= credit[i] + CNT_W'(1);
            end else if (grant[i] && !keep[i]) begin
               credit[i] <= credit[i] - CNT_W'(1);
            end
         end
         if (found && out_ready)
            rr <= (sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1);
      end
   end

endmodule

// File: tb/tb_token_thin_arbiter.sv
// Testbench for token_thin_arbiter (N_REQ=4, CNT_W=4, RATIO_W=3).
// A token-count model tracks, per requester, tokens seen since the last kept
// one and the number of credits outstanding; outputs are checked against it
// after every clock, and directed scenarios carry hand-computed literals.
module tb_token_thin_arbiter;

   localparam int N    = 4;
   localparam int MAXC = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  a;
   logic [2:0]  ratio;
   logic        out_ready;
   logic        out_valid;
   logic [1:0]  out_id;
   logic [3:0]  drop;
   logic [15:0] pending;

   token_thin_arbiter #(.N_REQ(4), .CNT_W(4), .RATIO_W(3)) dut (
      .clk(clk), .rst(rst), .a(a), .ratio(ratio), .out_ready(out_ready),
      .out_valid(out_valid), .out_id(out_id), .drop(drop), .pending(pending)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state
   int m_seen   [N];
   int m_credit [N];
   int m_drop   [N];
   int m_rr;

   int cyc;
   int xfer_id  [$];
   int xfer_edge[$];

   function automatic int model_pick();
      for (int k = 0; k < N; k++)
         if (m_credit[(m_rr + k) % N] > 0) return (m_rr + k) % N;
      return -1;
   endfunction

   initial begin
      for (int i = 0; i < N; i++) begin
         m_seen[i] = 0; m_credit[i] = 0; m_drop[i] = 0;
      end
      m_rr = 0;
   end

   always @(posedge clk) begin : model
      int eff, gid, nc, kp, g;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_seen[i] <= 0; m_credit[i] <= 0; m_drop[i] <= 0;
         end
         m_rr <= 0;
      end else begin
         eff = (ratio == 0) ? 1 : int'(ratio);
         gid = model_pick();
         for (int i = 0; i < N; i++) begin
            kp = (a[i] && (m_seen[i] + 1 >= eff)) ? 1 : 0;
            if (a[i]) m_seen[i] <= kp ? 0 : m_seen[i] + 1;
            g  = (gid == i && out_ready) ? 1 : 0;
            nc = m_credit[i] + kp - g;
            m_drop[i]   <= (nc > MAXC) ? 1 : 0;
            m_credit[i] <= (nc > MAXC) ? MAXC : nc;
         end
         if (gid >= 0 && out_ready) m_rr <= (gid + 1) % N;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int gid, ep, ed;
      gid = model_pick();
      ep = 0; ed = 0;
      for (int i = 0; i < N; i++) begin
         ep |= m_credit[i] << (i * 4);
         ed |= m_drop[i] << i;
      end
      chk("model out_valid", int'(out_valid), (gid >= 0) ? 1 : 0);
      chk("model out_id",    int'(out_id),    (gid >= 0) ? gid : 0);
      chk("model pending",   int'(pending),   ep);
      chk("model drop",      int'(drop),      ed);
   endtask

   // Drive inputs for the next edge, note any transfer, then check after it.
   task automatic tick(input logic [3:0] av, input logic [2:0] rv,
                       input logic rdy, input logic rs);
      a = av; ratio = rv; out_ready = rdy; rst = rs;
      if (out_valid && rdy && !rs) begin
         xfer_id.push_back(int'(out_id));
         xfer_edge.push_back(cyc + 1);
      end
      @(negedge clk);
      cyc++;
      check_model();
   endtask

   task automatic start_test();
      tick(4'b0000, 3'd1, 1'b0, 1'b1);
      cyc = 0;
      xfer_id.delete();
      xfer_edge.delete();
   endtask

   int drops;

   initial begin
      rst = 1'b1; a = '0; ratio = 3'd1; out_ready = 1'b0;
      cyc = 0;
      @(negedge clk);

      // Reset state
      start_test();
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_id",    int'(out_id),    0);
      chk("reset pending",   int'(pending),   0);
      chk("reset drop",      int'(drop),      0);

      // Halving: 8 tokens at ratio 2 -> transfers on edges 3,5,7,9, id 0
      start_test();
      for (int i = 0; i < 12; i++) tick((i < 8) ? 4'b0001 : 4'b0000, 3'd2, 1'b1, 1'b0);
      chk("halving count", xfer_id.size(), 4);
      for (int k = 0; k < xfer_id.size() && k < 4; k++) begin
         chk("halving id",   xfer_id[k],   0);
         chk("halving edge", xfer_edge[k], 3 + 2 * k);
      end

      // Fairness: 3 credits each, then 0,1,2,3 x3
      start_test();
      for (int i = 0; i < 3; i++) tick(4'b1111, 3'd1, 1'b0, 1'b0);
      chk("fair pending", int'(pending), 16'h3333);
      for (int i = 0; i < 14; i++) tick(4'b0000, 3'd1, 1'b1, 1'b0);
      chk("fair count", xfer_id.size(), 12);
      for (int k = 0; k < xfer_id.size() && k < 12; k++)
         chk("fair id", xfer_id[k], k % 4);
      chk("fair drained", int'(out_valid), 0);

      // Simultaneous keep and grant on requester 2
      start_test();
      tick(4'b0100, 3'd1, 1'b0, 1'b0);
      chk("simul pre credit", int'(pending[11:8]), 1);
      tick(4'b0100, 3'd1, 1'b1, 1'b0);
      chk("simul credit", int'(pending[11:8]), 1);
      chk("simul drop",   int'(drop), 0);
      chk("simul id",     (xfer_id.size() == 1) ? xfer_id[0] : -1, 2);

      // Saturation on requester 1
      start_test();
      drops = 0;
      for (int i = 1; i <= 17; i++) begin
         tick(4'b0010, 3'd1, 1'b0, 1'b0);
         if (drop[1]) drops++;
         if (i == 15) chk("sat no drop yet", int'(drop), 0);
         if (i == 16) chk("sat drop 16", int'(drop), 4'b0010);
      end
      chk("sat credit", int'(pending[7:4]), 15);
      chk("sat drop 17", int'(drop), 4'b0010);
      chk("sat drop count", drops, 2);
      tick(4'b0000, 3'd1, 1'b0, 1'b0);
      chk("sat drop clear", int'(drop), 0);

      // Ratio change 3 -> 1
      start_test();
      for (int i = 0; i < 3; i++) tick(4'b0001, 3'd3, 1'b0, 1'b0);
      chk("ratio3 keep 3rd", int'(pending[3:0]), 1);
      for (int i = 0; i < 2; i++) tick(4'b0001, 3'd3, 1'b0, 1'b0);
      chk("ratio3 two discarded", int'(pending[3:0]), 1);
      tick(4'b0001, 3'd1, 1'b0, 1'b0);
      chk("ratio drop keeps now", int'(pending[3:0]), 2);
      tick(4'b0001, 3'd1, 1'b0, 1'b0);
      chk("ratio phase zero", int'(pending[3:0]), 3);

      // Reset mid-stream: leave req0 with credits and phase 1 at ratio 2
      tick(4'b0001, 3'd2, 1'b0, 1'b0);
      chk("mid pre credit", int'(pending[3:0]), 3);
      tick(4'b0001, 3'd2, 1'b1, 1'b1);
      chk("mid rst valid",   int'(out_valid), 0);
      chk("mid rst pending", int'(pending),   0);
      chk("mid rst drop",    int'(drop),      0);
      tick(4'b0001, 3'd2, 1'b0, 1'b0);
      chk("mid phase restart 1", int'(pending[3:0]), 0);
      tick(4'b0001, 3'd2, 1'b0, 1'b0);
      chk("mid phase restart 2", int'(pending[3:0]), 1);

      // ratio 0 behaves as 1
      start_test();
      for (int i = 0; i < 3; i++) tick(4'b0001, 3'd0, 1'b0, 1'b0);
      chk("ratio0 credit", int'(pending[3:0]), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
